mult_rr_scheduler: RTL and testbench



---
 rtl/mult_rr_scheduler.sv | 133 +++++++++++++
 tb/tb_mult_rr_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: one sequential shift-add multiplier shared by NUM_REQ
// requesters through a round-robin arbiter. The product is returned on a
// valid/ready port and tagged with the owning requester index.
// Optional build macro MULT_ZERO_SKIP_EN: end the MUL phase early once all
// remaining multiplier bits are zero. Results are identical either way.
module mult_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PROD_W   = 2 * BIT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   multiplicand_in,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   multiplier_in,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [ID_W-1:0]                result_id,
  output logic [PROD_W-1:0]              result
);

  localparam int STEP_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                     state_q, state_d;
  logic        [ID_W-1:0]     ptr_q, ptr_d;
  logic        [ID_W-1:0]     result_id_q, result_id_d;
  logic signed [PROD_W-1:0]   acc_q, acc_d;
  logic signed [PROD_W-1:0]   mcand_q, mcand_d;
  logic        [BIT_WIDTH-1:0] mplier_q, mplier_d;
  logic        [STEP_W-1:0]   step_q, step_d;

  logic                       win_any;
  logic        [ID_W-1:0]     win_idx;
  logic        [ID_W-1:0]     win_nxt;

  // Two's-complement multiplicand widened to the product width.
  function automatic logic signed [PROD_W-1:0] sext(input logic [BIT_WIDTH-1:0] v);
    return {{BIT_WIDTH{v[BIT_WIDTH-1]}}, v};
  endfunction

  // Round-robin pick: first asserted req at ptr, ptr+1, ... (mod NUM_REQ).
  // Scanning offsets downward lets the smallest offset win last.
  always_comb begin
    int j;
    win_any = 1'b0;
    win_idx = '0;
    win_nxt = '0;
    j       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        win_any = 1'b1;
        win_idx = ID_W'(j);
        win_nxt = (j + 1 == NUM_REQ) ? '0 : ID_W'(j + 1);
      end
    end
  end

  // Next-state, datapath update and grant generation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    result_id_d = result_id_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    step_d      = step_q;
    gnt         = '0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          gnt[win_idx] = 1'b1;
          mcand_d      = sext(multiplicand_in[win_idx*BIT_WIDTH +: BIT_WIDTH]);
          mplier_d     = multiplier_in[win_idx*BIT_WIDTH +: BIT_WIDTH];
          acc_d        = '0;
          step_d       = '0;
          result_id_d  = win_idx;
          ptr_d        = win_nxt;
          state_d      = MUL;
        end
      end
      MUL: begin
        // Multiplier is consumed LSB first, so bit 0 is always step k's bit.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q <<< 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + 1'b1;
`ifdef MULT_ZERO_SKIP_EN
        if (mplier_q[BIT_WIDTH-1:1] == '0) state_d = DONE;
`else
        if (step_q == STEP_W'(BIT_WIDTH - 1)) state_d = DONE;
`endif
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      result_id_q <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      result_id_q <= result_id_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      step_q      <= step_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result_id    = result_id_q;
  assign result       = acc_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
module tb_mult_rr_scheduler;
  localparam int NR = 4;
  localparam int BW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req;
  logic [NR*BW-1:0] a_in, b_in;
  logic [NR-1:0]  gnt;
  logic           busy, result_valid, result_ready;
  logic [1:0]     result_id;
  logic [2*BW-1:0] result;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  mult_rr_scheduler #(.NUM_REQ(NR), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .multiplicand_in(a_in), .multiplier_in(b_in),
    .gnt(gnt), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_id(result_id), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the grant cycle to the first result_valid cycle.
  function automatic int exp_lat(input logic [BW-1:0] b);
    int m;
`ifdef MULT_ZERO_SKIP_EN
    m = 1;
    for (int k = 0; k < BW; k++) if (b[k]) m = k + 1;
`else
    m = BW;
`endif
    return m + 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '0; result_ready = 1'b1; a_in = '0; b_in = '0;
    tick();
    n_chk++;
    if ({gnt, busy, result_valid, result_id, result} !== '0)
      $display("FAIL reset_outputs got gnt=%b busy=%b vld=%b id=%0d res=%h, want all 0",
               gnt, busy, result_valid, result_id, result);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // One directed product on requester idx with hand-computed expectation.
  task automatic run_one(input int idx, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [7:0] want, input int want_lat, input string nm);
    int n;
    a_in[idx*BW +: BW] = a;
    b_in[idx*BW +: BW] = b;
    req = '0; req[idx] = 1'b1;
    #1;
    n_chk++;
    if (gnt !== NR'(1 << idx)) $display("FAIL %s_gnt got %b want %b", nm, gnt, NR'(1 << idx));
    else n_pass++;
    tick();
    req = '0;
    n_chk++;
    if (busy !== 1'b1 || gnt !== '0) $display("FAIL %s_busy got busy=%b gnt=%b want 1/0", nm, busy, gnt);
    else n_pass++;
    n = 1;
    while (!result_valid && n < 30) begin tick(); n++; end
    n_chk++;
    if (n !== want_lat) $display("FAIL %s_latency got %0d want %0d", nm, n, want_lat);
    else n_pass++;
    n_chk++;
    if (result !== want || result_id !== 2'(idx))
      $display("FAIL %s_result got %h id %0d want %h id %0d", nm, result, result_id, want, idx);
    else n_pass++;
    tick();
    n_chk++;
    if (result_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_after_xfer got vld=%b busy=%b want 0/0", nm, result_valid, busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_one(0, 4'd3, 4'd5, 8'h0F, exp_lat(4'd5), "t1_3x5");
  endtask

  task automatic test_signed();
    run_one(2, 4'hD, 4'd6,  8'hEE, exp_lat(4'd6),  "t2_m3x6");
    run_one(2, 4'h8, 4'hF,  8'h88, exp_lat(4'hF),  "t2_m8x15");
    run_one(2, 4'h7, 4'hF,  8'h69, exp_lat(4'hF),  "t2_7x15");
  endtask

  task automatic test_round_robin();
    int last, n;
    test_reset();
    a_in = {4'd1, 4'd1, 4'd1, 4'd1};
    b_in = {4'hF, 4'hF, 4'hF, 4'hF};
    req  = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      #1;
      n = 0;
      while (gnt === '0 && n < 20) begin tick(); n++; end
      n_chk++;
      if (gnt !== NR'(1 << (g % NR))) $display("FAIL rr_order%0d got %b want %b", g, gnt, NR'(1 << (g % NR)));
      else n_pass++;
      if (g > 0) begin
        n_chk++;
        if (cyc - last !== 6) $display("FAIL rr_spacing%0d got %0d want 6", g, cyc - last);
        else n_pass++;
      end
      last = cyc;
      tick();
      n = 0;
      while (!result_valid && n < 20) begin tick(); n++; end
      n_chk++;
      if (result_id !== 2'(g % NR) || result !== 8'h0F)
        $display("FAIL rr_id%0d got id %0d res %h want id %0d res 0f", g, result_id, result, g % NR);
      else n_pass++;
      tick();
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_stall();
    int n;
    test_reset();
    a_in = '0; b_in = '0;
    a_in[1*BW +: BW] = 4'd2; b_in[1*BW +: BW] = 4'd3;
    a_in[3*BW +: BW] = 4'd1; b_in[3*BW +: BW] = 4'd1;
    result_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'b1000;
    n = 0;
    while (!result_valid && n < 20) begin tick(); n++; end
    for (int c = 0; c < 10; c++) begin
      n_chk++;
      if (result_valid !== 1'b1 || result !== 8'h06 || result_id !== 2'd1 || gnt !== '0)
        $display("FAIL stall_hold%0d got vld=%b res=%h id=%0d gnt=%b want 1/06/1/0000",
                 c, result_valid, result, result_id, gnt);
      else n_pass++;
      tick();
    end
    result_ready = 1'b1;
    tick();
    n_chk++;
    if (gnt !== 4'b1000) $display("FAIL stall_next_gnt got %b want 1000", gnt);
    else n_pass++;
    tick();
    req = '0;
    n = 0;
    while (!result_valid && n < 20) begin tick(); n++; end
    n_chk++;
    if (result_id !== 2'd3 || result !== 8'h01) $display("FAIL stall_second got id %0d res %h want 3/01", result_id, result);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    a_in[3*BW +: BW] = 4'd1; b_in[3*BW +: BW] = 4'd8;
    req = 4'b1000;
    #1;
    tick();
    req = '0;
    tick();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({gnt, busy, result_valid, result_id, result} !== '0)
      $display("FAIL midrst_outputs got gnt=%b busy=%b vld=%b id=%0d res=%h want all 0",
               gnt, busy, result_valid, result_id, result);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_chk++;
      if (result_valid !== 1'b0) $display("FAIL midrst_no_valid%0d got %b want 0", c, result_valid);
      else n_pass++;
    end
    a_in[0 +: BW] = 4'd2; b_in[0 +: BW] = 4'd2;
    req = 4'b1001;
    #1;
    n_chk++;
    if (gnt !== 4'b0001) $display("FAIL midrst_ptr got %b want 0001", gnt);
    else n_pass++;
    tick();
    req = '0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_zero_skip();
`ifdef MULT_ZERO_SKIP_EN
    run_one(1, 4'd5, 4'd0, 8'h00, 2, "t6_b0");
    run_one(1, 4'd5, 4'd2, 8'h0A, 3, "t6_b2");
    run_one(1, 4'd5, 4'd8, 8'h28, 5, "t6_b8");
`else
    run_one(1, 4'd5, 4'd0, 8'h00, 5, "t6_b0");
    run_one(1, 4'd5, 4'd2, 8'h0A, 5, "t6_b2");
    run_one(1, 4'd5, 4'd8, 8'h28, 5, "t6_b8");
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_round_robin();
    test_stall();
    test_reset_mid_mul();
    test_zero_skip();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
